// File: rtl/core_dual_issue.sv
// Dual-issue in-order issue stage: picks 0/1/2 instructions from the FIFO head
// using pair hazard rules and a scoreboard of in-flight long-latency writes.
module core_dual_issue #(
  parameter int PAYLOAD_WIDTH = 128,
  parameter int NREG          = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic [1:0]                 inst_valid_i,
  input  logic [2*PAYLOAD_WIDTH-1:0] payload_i,
  input  logic [9:0]                 r0_i,
  input  logic [9:0]                 r1_i,
  input  logic [9:0]                 w_i,
  input  logic [1:0]                 long_lat_i,
  input  logic [1:0]                 single_i,
  output logic [1:0]                 read_num_o,
  output logic [1:0]                 issue_valid_o,
  output logic [2*PAYLOAD_WIDTH-1:0] issue_payload_o,
  input  logic                       issue_ready_i,
  input  logic [1:0]                 wb_valid_i,
  input  logic [9:0]                 wb_reg_i,
  output logic [31:0]                stall_cnt_o
);

  logic [NREG-1:0] sb;
  logic [NREG-1:0] sb_set;
  logic [NREG-1:0] sb_clr;
  logic [NREG-1:0] sb_next;

  logic [4:0] s0_r0, s0_r1, s0_w;
  logic [4:0] s1_r0, s1_r1, s1_w;
  logic [4:0] wb0_reg, wb1_reg;

  logic load;
  logic hit0, hit1;
  logic pair_raw, pair_waw;
  logic issue0, issue1;

  logic [2*PAYLOAD_WIDTH-1:0] payload_next;

  assign s0_r0   = r0_i[4:0];
  assign s0_r1   = r1_i[4:0];
  assign s0_w    = w_i[4:0];
  assign s1_r0   = r0_i[9:5];
  assign s1_r1   = r1_i[9:5];
  assign s1_w    = w_i[9:5];
  assign wb0_reg = wb_reg_i[4:0];
  assign wb1_reg = wb_reg_i[9:5];

  function automatic logic sb_hit(input logic [NREG-1:0] board,
                                  input logic [4:0] a,
                                  input logic [4:0] b,
                                  input logic [4:0] d);
    sb_hit = ((a != 5'd0) && board[a]) ||
             ((b != 5'd0) && board[b]) ||
             ((d != 5'd0) && board[d]);
  endfunction

  assign load = !issue_valid_o[0] || issue_ready_i;

  // Hazards look only at the registered scoreboard, so wb_* never reaches read_num_o.
  assign hit0 = sb_hit(sb, s0_r0, s0_r1, s0_w);
  assign hit1 = sb_hit(sb, s1_r0, s1_r1, s1_w);

  assign pair_raw = (s0_w != 5'd0) && ((s1_r0 == s0_w) || (s1_r1 == s0_w));
  assign pair_waw = (s0_w != 5'd0) && (s1_w == s0_w);

  assign issue0 = !rst && inst_valid_i[0] && load && !flush_i && !hit0;

  assign issue1 = issue0 && inst_valid_i[1] &&
                  !single_i[0] && !single_i[1] &&
                  !hit1 &&
                  !(long_lat_i[0] && long_lat_i[1]) &&
                  !pair_raw && !pair_waw;

  assign read_num_o = issue1 ? 2'd2 : (issue0 ? 2'd1 : 2'd0);

  always_comb begin
    sb_set = '0;
    sb_clr = '0;
    if (issue0 && long_lat_i[0] && (s0_w != 5'd0)) sb_set[s0_w] = 1'b1;
    if (issue1 && long_lat_i[1] && (s1_w != 5'd0)) sb_set[s1_w] = 1'b1;
    if (wb_valid_i[0]) sb_clr[wb0_reg] = 1'b1;
    if (wb_valid_i[1]) sb_clr[wb1_reg] = 1'b1;
    // Set is applied after clear so a same-cycle set of the same bit wins.
    sb_next    = (sb & ~sb_clr) | sb_set;
    sb_next[0] = 1'b0;
  end

  always_comb begin
    payload_next = '0;
    if (issue0) payload_next[PAYLOAD_WIDTH-1:0] = payload_i[PAYLOAD_WIDTH-1:0];
    if (issue1) payload_next[2*PAYLOAD_WIDTH-1:PAYLOAD_WIDTH] =
                  payload_i[2*PAYLOAD_WIDTH-1:PAYLOAD_WIDTH];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sb <= '0;
    end else if (flush_i) begin
      sb <= '0;
    end else begin
      sb <= sb_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      issue_valid_o   <= '0;
      issue_payload_o <= '0;
    end else if (flush_i) begin
      issue_valid_o <= '0;
    end else if (load) begin
      issue_valid_o   <= {issue1, issue0};
      issue_payload_o <= payload_next;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
    end else if (inst_valid_i[0] && (read_num_o == 2'd0) && !flush_i &&
                 (stall_cnt_o != '1)) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_core_dual_issue.sv
// Directed self-checking bench for core_dual_issue: pair hazards, scoreboard,
// backpressure, flush and reset behaviour against hand-computed expectations.
module tb_core_dual_issue;

  localparam int PW = 128;

  logic          clk;
  logic          rst;
  logic          flush;
  logic [1:0]    iv;
  logic [2*PW-1:0] pay;
  logic [9:0]    r0, r1, w;
  logic [1:0]    ll, single;
  logic [1:0]    read_num;
  logic [1:0]    issue_valid;
  logic [2*PW-1:0] issue_payload;
  logic          ready;
  logic [1:0]    wbv;
  logic [9:0]    wbr;
  logic [31:0]   stall_cnt;

  int checks;
  int fails;
  logic [31:0] exp_stall;

  localparam logic [PW-1:0] P_A   = 128'hA0A0_0000_0000_0000_0000_0000_0000_0001;
  localparam logic [PW-1:0] P_B   = 128'hB0B0_0000_0000_0000_0000_0000_0000_0002;
  localparam logic [PW-1:0] P_C   = 128'hC0C0_0000_0000_0000_0000_0000_0000_0003;
  localparam logic [PW-1:0] P_D   = 128'hD0D0_0000_0000_0000_0000_0000_0000_0004;
  localparam logic [PW-1:0] P_E   = 128'hE0E0_0000_0000_0000_0000_0000_0000_0005;
  localparam logic [PW-1:0] P_F   = 128'hF0F0_0000_0000_0000_0000_0000_0000_0006;
  localparam logic [PW-1:0] P_LD  = 128'h1D1D_0000_0000_0000_0000_0000_0000_0007;
  localparam logic [PW-1:0] P_DEP = 128'hDE9D_0000_0000_0000_0000_0000_0000_0008;

  core_dual_issue #(.PAYLOAD_WIDTH(PW), .NREG(32)) dut (
    .clk             (clk),
    .rst             (rst),
    .flush_i         (flush),
    .inst_valid_i    (iv),
    .payload_i       (pay),
    .r0_i            (r0),
    .r1_i            (r1),
    .w_i             (w),
    .long_lat_i      (ll),
    .single_i        (single),
    .read_num_o      (read_num),
    .issue_valid_o   (issue_valid),
    .issue_payload_o (issue_payload),
    .issue_ready_i   (ready),
    .wb_valid_i      (wbv),
    .wb_reg_i        (wbr),
    .stall_cnt_o     (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_in();
    flush = 1'b0; iv = '0; pay = '0; r0 = '0; r1 = '0; w = '0;
    ll = '0; single = '0; wbv = '0; wbr = '0;
  endtask

  task automatic slot(input int s, input logic [4:0] a, input logic [4:0] b,
                      input logic [4:0] d, input logic lat, input logic sg,
                      input logic [PW-1:0] p);
    iv[s]          = 1'b1;
    r0[s*5 +: 5]   = a;
    r1[s*5 +: 5]   = b;
    w[s*5 +: 5]    = d;
    ll[s]          = lat;
    single[s]      = sg;
    pay[s*PW +: PW] = p;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; ready = 1'b1;
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_A);
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL reset_read_num got %0d exp 0", read_num); fails++;
    end
    tick(); tick();
    checks++;
    if (issue_valid !== 2'b00) begin
      $display("FAIL reset_valid got %b exp 00", issue_valid); fails++;
    end
    checks++;
    if (issue_payload !== '0) begin
      $display("FAIL reset_payload got %h exp 0", issue_payload); fails++;
    end
    checks++;
    if (stall_cnt !== 32'd0) begin
      $display("FAIL reset_stall got %0d exp 0", stall_cnt); fails++;
    end
    rst = 1'b0;
    clear_in();
    tick();
  endtask

  task automatic test_independent();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_A);
    slot(1, 5'd4, 5'd6, 5'd5, 1'b0, 1'b0, P_B);
    #1;
    checks++;
    if (read_num !== 2'd2) begin
      $display("FAIL indep_read_num got %0d exp 2", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b11) begin
      $display("FAIL indep_valid got %b exp 11", issue_valid); fails++;
    end
    checks++;
    if (issue_payload !== {P_B, P_A}) begin
      $display("FAIL indep_payload got %h exp %h", issue_payload, {P_B, P_A}); fails++;
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      $display("FAIL indep_stall got %0d exp %0d", stall_cnt, exp_stall); fails++;
    end
  endtask

  task automatic test_raw_pair();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd7, 1'b0, 1'b0, P_A);
    slot(1, 5'd7, 5'd3, 5'd9, 1'b0, 1'b0, P_B);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL raw_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b01 || issue_payload[PW-1:0] !== P_A) begin
      $display("FAIL raw_out got %b/%h exp 01/%h", issue_valid, issue_payload[PW-1:0], P_A);
      fails++;
    end
    clear_in();
    slot(0, 5'd7, 5'd3, 5'd9, 1'b0, 1'b0, P_B);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL raw_followup_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
  endtask

  task automatic test_scoreboard();
    clear_in();
    slot(0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, P_LD);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL sb_load_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b01 || issue_payload[PW-1:0] !== P_LD) begin
      $display("FAIL sb_load_out got %b/%h exp 01/%h", issue_valid, issue_payload[PW-1:0], P_LD);
      fails++;
    end
    clear_in();
    slot(0, 5'd8, 5'd0, 5'd11, 1'b0, 1'b0, P_DEP);
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL sb_block_read_num got %0d exp 0", read_num); fails++;
    end
    tick();
    exp_stall = exp_stall + 1;
    checks++;
    if (stall_cnt !== exp_stall) begin
      $display("FAIL sb_block_stall got %0d exp %0d", stall_cnt, exp_stall); fails++;
    end
    checks++;
    if (issue_valid !== 2'b00) begin
      $display("FAIL sb_bubble_valid got %b exp 00", issue_valid); fails++;
    end
    wbv = 2'b01; wbr = 10'd8;
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL sb_wb_same_cycle got %0d exp 0", read_num); fails++;
    end
    tick();
    exp_stall = exp_stall + 1;
    checks++;
    if (stall_cnt !== exp_stall) begin
      $display("FAIL sb_wb_stall got %0d exp %0d", stall_cnt, exp_stall); fails++;
    end
    wbv = '0; wbr = '0;
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL sb_unblock_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b01 || issue_payload[PW-1:0] !== P_DEP) begin
      $display("FAIL sb_unblock_out got %b/%h exp 01/%h", issue_valid, issue_payload[PW-1:0], P_DEP);
      fails++;
    end
  endtask

  task automatic test_backpressure();
    ready = 1'b1;
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_C);
    slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, P_D);
    tick();
    checks++;
    if (issue_valid !== 2'b11 || issue_payload !== {P_D, P_C}) begin
      $display("FAIL bp_first_load got %b/%h exp 11/%h", issue_valid, issue_payload, {P_D, P_C});
      fails++;
    end
    ready = 1'b0;
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_E);
    slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, P_F);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (read_num !== 2'd0) begin
        $display("FAIL bp_hold_read_num[%0d] got %0d exp 0", i, read_num); fails++;
      end
      tick();
      exp_stall = exp_stall + 1;
      checks++;
      if (issue_valid !== 2'b11 || issue_payload !== {P_D, P_C}) begin
        $display("FAIL bp_hold_out[%0d] got %b/%h exp 11/%h", i, issue_valid, issue_payload, {P_D, P_C});
        fails++;
      end
      checks++;
      if (stall_cnt !== exp_stall) begin
        $display("FAIL bp_hold_stall[%0d] got %0d exp %0d", i, stall_cnt, exp_stall); fails++;
      end
    end
    ready = 1'b1;
    #1;
    checks++;
    if (read_num !== 2'd2) begin
      $display("FAIL bp_release_read_num got %0d exp 2", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b11 || issue_payload !== {P_F, P_E}) begin
      $display("FAIL bp_release_out got %b/%h exp 11/%h", issue_valid, issue_payload, {P_F, P_E});
      fails++;
    end
  endtask

  task automatic test_single_longlat();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b1, P_A);
    slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b0, P_B);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL single0_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_A);
    slot(1, 5'd4, 5'd5, 5'd6, 1'b0, 1'b1, P_B);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL single1_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, P_C);
    slot(1, 5'd3, 5'd4, 5'd0, 1'b1, 1'b0, P_D);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL longlat_pair_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    clear_in();
    slot(0, 5'd1, 5'd2, 5'd14, 1'b0, 1'b0, P_E);
    slot(1, 5'd3, 5'd4, 5'd14, 1'b0, 1'b0, P_F);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL waw_pair_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
  endtask

  task automatic test_set_clear();
    clear_in();
    slot(0, 5'd0, 5'd0, 5'd10, 1'b1, 1'b0, P_LD);
    wbv = 2'b01; wbr = 10'd10;
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL setclr_issue_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    clear_in();
    slot(0, 5'd1, 5'd0, 5'd2, 1'b0, 1'b0, P_A);
    slot(1, 5'd10, 5'd0, 5'd3, 1'b0, 1'b0, P_B);
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL setclr_slot1_hit got %0d exp 1", read_num); fails++;
    end
    tick();
    clear_in();
    slot(0, 5'd10, 5'd0, 5'd12, 1'b0, 1'b0, P_DEP);
    wbv = 2'b10; wbr = {5'd10, 5'd0};
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL setclr_block_read_num got %0d exp 0", read_num); fails++;
    end
    tick();
    exp_stall = exp_stall + 1;
    wbv = '0; wbr = '0;
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL setclr_unblock_read_num got %0d exp 1", read_num); fails++;
    end
    tick();
    checks++;
    if (stall_cnt !== exp_stall) begin
      $display("FAIL setclr_stall got %0d exp %0d", stall_cnt, exp_stall); fails++;
    end
  endtask

  task automatic test_flush();
    clear_in();
    slot(0, 5'd0, 5'd0, 5'd8, 1'b1, 1'b0, P_LD);
    tick();
    clear_in();
    slot(0, 5'd0, 5'd0, 5'd9, 1'b1, 1'b0, P_LD);
    tick();
    checks++;
    if (issue_valid !== 2'b01) begin
      $display("FAIL flush_pre_valid got %b exp 01", issue_valid); fails++;
    end
    clear_in();
    flush = 1'b1;
    slot(0, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_A);
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL flush_read_num got %0d exp 0", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b00) begin
      $display("FAIL flush_valid got %b exp 00", issue_valid); fails++;
    end
    checks++;
    if (stall_cnt !== exp_stall) begin
      $display("FAIL flush_stall got %0d exp %0d", stall_cnt, exp_stall); fails++;
    end
    clear_in();
    slot(0, 5'd8, 5'd0, 5'd15, 1'b0, 1'b0, P_C);
    slot(1, 5'd9, 5'd0, 5'd16, 1'b0, 1'b0, P_D);
    #1;
    checks++;
    if (read_num !== 2'd2) begin
      $display("FAIL flush_sb_cleared got %0d exp 2", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b11 || issue_payload !== {P_D, P_C}) begin
      $display("FAIL flush_after_out got %b/%h exp 11/%h", issue_valid, issue_payload, {P_D, P_C});
      fails++;
    end
    clear_in();
    slot(1, 5'd1, 5'd2, 5'd3, 1'b0, 1'b0, P_E);
    iv = 2'b10;
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL slot1_only_read_num got %0d exp 0", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b00 || stall_cnt !== exp_stall) begin
      $display("FAIL slot1_only_state got %b/%0d exp 00/%0d", issue_valid, stall_cnt, exp_stall);
      fails++;
    end
  endtask

  task automatic test_reset_mid();
    clear_in();
    slot(0, 5'd0, 5'd0, 5'd20, 1'b1, 1'b0, P_LD);
    tick();
    clear_in();
    rst = 1'b1;
    slot(0, 5'd20, 5'd0, 5'd21, 1'b0, 1'b0, P_DEP);
    #1;
    checks++;
    if (read_num !== 2'd0) begin
      $display("FAIL midrst_read_num got %0d exp 0", read_num); fails++;
    end
    tick();
    exp_stall = 32'd0;
    checks++;
    if (issue_valid !== 2'b00 || issue_payload !== '0 || stall_cnt !== exp_stall) begin
      $display("FAIL midrst_state got %b/%h/%0d exp 00/0/0", issue_valid, issue_payload, stall_cnt);
      fails++;
    end
    rst = 1'b0;
    #1;
    checks++;
    if (read_num !== 2'd1) begin
      $display("FAIL midrst_sb_cleared got %0d exp 1", read_num); fails++;
    end
    tick();
    checks++;
    if (issue_valid !== 2'b01 || issue_payload[PW-1:0] !== P_DEP) begin
      $display("FAIL midrst_after_out got %b/%h exp 01/%h", issue_valid, issue_payload[PW-1:0], P_DEP);
      fails++;
    end
  endtask

  initial begin
    checks    = 0;
    fails     = 0;
    exp_stall = 32'd0;
    test_reset();
    test_independent();
    test_raw_pair();
    test_scoreboard();
    test_backpressure();
    test_single_longlat();
    test_set_clear();
    test_flush();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
